// File: rtl/clarvi_serial_alu_pkg.sv
// Shared types for the digit-serial ALU: operation codes, sequencer states,
// and helpers that classify operations by digit order and word-op support.
package clarvi_serial_alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLT  = 4'd2,
        ALU_SLTU = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_AND  = 4'd6,
        ALU_SL   = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } serial_alu_state_t;

    // Compares and right shifts walk from the most significant digit down.
    function automatic logic is_msb_first(alu_op_t op);
        return op inside {ALU_SLT, ALU_SLTU, ALU_SRL, ALU_SRA};
    endfunction

    function automatic logic is_word_op(alu_op_t op);
        return op inside {ALU_ADD, ALU_SUB, ALU_SL, ALU_SRL, ALU_SRA};
    endfunction

endpackage

// File: rtl/clarvi_digit_unit.sv
// Combinational per-digit slice: add/sub with carry, magnitude compare and
// bitwise logic on one DIGIT_W-wide digit.
module clarvi_digit_unit
    import clarvi_serial_alu_pkg::*;
#(
    parameter int DIGIT_W = 8
) (
    input  alu_op_t              op,
    input  logic [DIGIT_W-1:0]   a,
    input  logic [DIGIT_W-1:0]   b,
    input  logic                 carry_in,
    input  logic                 signed_top,
    output logic [DIGIT_W-1:0]   y,
    output logic                 carry_out,
    output logic                 dig_eq,
    output logic                 dig_lt
);

    logic [DIGIT_W-1:0] b_eff;
    logic [DIGIT_W:0]   sum;

    // NOTE: every output gets a default first so no path through the case leaves a latch.
    always_comb begin
        b_eff     = (op == ALU_SUB) ? ~b : b;
        sum       = {1'b0, a} + {1'b0, b_eff} + {{DIGIT_W{1'b0}}, carry_in};
        carry_out = sum[DIGIT_W];
        dig_eq    = (a == b);
        dig_lt    = signed_top ? ($signed(a) < $signed(b)) : (a < b);
        y         = '0;
        case (op)
            ALU_ADD, ALU_SUB: y = sum[DIGIT_W-1:0];
            ALU_XOR:          y = a ^ b;
            ALU_OR:           y = a | b;
            ALU_AND:          y = a & b;
            default:          y = '0;
        endcase
    end

endmodule

// File: rtl/clarvi_serial_alu.sv
// Digit-serial integer ALU: accepts a full-width op, walks it over
// XLEN/DIGIT_W digits with its own sequencer, and returns a registered result.
module clarvi_serial_alu
    import clarvi_serial_alu_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int DIGIT_W = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  alu_op_t         op,
    input  logic            is32,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] opb,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int SHAMT_W = $clog2(XLEN);
    localparam int N_FULL  = XLEN / DIGIT_W;
    localparam int N_WORD  = (32 / DIGIT_W > 0) ? 32 / DIGIT_W : 1;
    localparam int IDX_W   = (N_FULL > 1) ? $clog2(N_FULL) : 1;

    if (!((XLEN == 32 || XLEN == 64) && DIGIT_W >= 8 && DIGIT_W <= XLEN &&
          ((DIGIT_W & (DIGIT_W - 1)) == 0))) begin : g_bad_params
        $error("clarvi_serial_alu: illegal XLEN/DIGIT_W combination");
    end

    serial_alu_state_t state;
    alu_op_t           op_q;
    logic              word_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic [XLEN-1:0]   acc_q;
    logic [SHAMT_W-1:0] shamt_q;
    logic [IDX_W-1:0]  step_q;
    logic              carry_q;
    logic              eq_q;
    logic              lt_q;

    logic [IDX_W-1:0]   last_step;
    logic [IDX_W-1:0]   pos;
    int                 base;
    logic [DIGIT_W-1:0] a_dig;
    logic [DIGIT_W-1:0] b_dig;
    logic [DIGIT_W-1:0] y_dig;
    logic               signed_top;
    logic               carry_out;
    logic               dig_eq;
    logic               dig_lt;
    logic [XLEN-1:0]    placed_a;
    logic [XLEN-1:0]    acc_next;
    logic [XLEN-1:0]    result_next;
    logic               carry_next;
    logic               eq_next;
    logic               lt_next;

    logic               word_in;
    logic [XLEN-1:0]    a_in;
    logic [SHAMT_W-1:0] shamt_in;
    logic [XLEN-1:0]    acc_init;
    logic [31:0]        sra_fill32;

    assign in_ready  = (state == IDLE) && !flush;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // Digit position: step counts up, MSB-first ops mirror it from the top.
    always_comb begin
        last_step  = word_q ? IDX_W'(N_WORD - 1) : IDX_W'(N_FULL - 1);
        pos        = is_msb_first(op_q) ? (last_step - step_q) : step_q;
        base       = int'(pos) * DIGIT_W;
        a_dig      = DIGIT_W'(a_q >> base);
        b_dig      = DIGIT_W'(b_q >> base);
        signed_top = (op_q == ALU_SLT) && (step_q == '0);
    end

    clarvi_digit_unit #(
        .DIGIT_W (DIGIT_W)
    ) u_digit (
        .op         (op_q),
        .a          (a_dig),
        .b          (b_dig),
        .carry_in   (carry_q),
        .signed_top (signed_top),
        .y          (y_dig),
        .carry_out  (carry_out),
        .dig_eq     (dig_eq),
        .dig_lt     (dig_lt)
    );

    always_comb begin
        placed_a   = XLEN'(a_dig) << base;
        acc_next   = acc_q;
        carry_next = carry_q;
        eq_next    = eq_q;
        lt_next    = lt_q;
        case (op_q)
            ALU_ADD, ALU_SUB: begin
                acc_next   = acc_q | (XLEN'(y_dig) << base);
                carry_next = carry_out;
            end
            ALU_XOR, ALU_OR, ALU_AND: acc_next = acc_q | (XLEN'(y_dig) << base);
            ALU_SL:                   acc_next = acc_q | (placed_a << shamt_q);
            ALU_SRL, ALU_SRA:         acc_next = acc_q | (placed_a >> shamt_q);
            ALU_SLT, ALU_SLTU: begin
                // The first differing digit from the top decides the ordering.
                if (eq_q && !dig_eq) begin
                    eq_next = 1'b0;
                    lt_next = dig_lt;
                end
            end
            default: ;
        endcase

        if (op_q == ALU_SLT || op_q == ALU_SLTU) begin
            result_next = XLEN'(lt_next);
        end else if (word_q) begin
            result_next = XLEN'($signed(acc_next[31:0]));
        end else begin
            result_next = acc_next;
        end
    end

    // Word ops see a zero-extended low half; SRA pre-loads its sign fill.
    always_comb begin
        word_in    = is32 && (XLEN == 64) && is_word_op(op);
        a_in       = rs1;
        shamt_in   = opb[SHAMT_W-1:0];
        sra_fill32 = rs1[31] ? ~(32'hFFFF_FFFF >> opb[4:0]) : 32'h0;
        acc_init   = '0;
        if (word_in) begin
            a_in     = XLEN'(rs1[31:0]);
            shamt_in = SHAMT_W'(opb[4:0]);
        end
        if (op == ALU_SRA) begin
            if (word_in) begin
                acc_init = XLEN'(sra_fill32);
            end else if (rs1[XLEN-1]) begin
                acc_init = ~({XLEN{1'b1}} >> shamt_in);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            op_q    <= ALU_ADD;
            word_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            shamt_q <= '0;
            step_q  <= '0;
            carry_q <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            result  <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state   <= RUN;
                        op_q    <= op;
                        word_q  <= word_in;
                        a_q     <= a_in;
                        b_q     <= opb;
                        shamt_q <= shamt_in;
                        acc_q   <= acc_init;
                        step_q  <= '0;
                        carry_q <= (op == ALU_SUB);
                        eq_q    <= 1'b1;
                        lt_q    <= 1'b0;
                    end
                end
                RUN: begin
                    acc_q   <= acc_next;
                    carry_q <= carry_next;
                    eq_q    <= eq_next;
                    lt_q    <= lt_next;
                    step_q  <= step_q + 1'b1;
                    if (step_q == last_step) begin
                        state  <= DONE;
                        result <= result_next;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clarvi_serial_alu.sv
// Self-checking bench: four ALU instances (DIGIT_W 8/16/32/64) exercised with
// directed cases and random ops against a plain-arithmetic reference model.
module tb_clarvi_serial_alu;
    import clarvi_serial_alu_pkg::*;

    logic        clock;
    logic        reset;
    logic        flush;
    logic [3:0]  in_valid_v;
    logic        out_ready;
    alu_op_t     op;
    logic        is32;
    logic [63:0] rs1;
    logic [63:0] opb;

    logic        in_ready_w  [4];
    logic        out_valid_w [4];
    logic        busy_w      [4];
    logic [63:0] result_w    [4];

    int n_checks = 0;
    int n_fail   = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        clarvi_serial_alu #(
            .XLEN    (64),
            .DIGIT_W (8 << g)
        ) u_dut (
            .clock     (clock),
            .reset     (reset),
            .flush     (flush),
            .in_valid  (in_valid_v[g]),
            .in_ready  (in_ready_w[g]),
            .op        (op),
            .is32      (is32),
            .rs1       (rs1),
            .opb       (opb),
            .out_valid (out_valid_w[g]),
            .out_ready (out_ready),
            .result    (result_w[g]),
            .busy      (busy_w[g])
        );
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit ref_is_word(alu_op_t o, bit w);
        return w && (o == ALU_ADD || o == ALU_SUB || o == ALU_SL || o == ALU_SRL || o == ALU_SRA);
    endfunction

    function automatic int ref_digits(int dw, alu_op_t o, bit w);
        if (ref_is_word(o, w)) return (32 / dw > 0) ? 32 / dw : 1;
        return 64 / dw;
    endfunction

    function automatic logic [63:0] ref_alu(alu_op_t o, bit w, logic [63:0] a, logic [63:0] b);
        logic [31:0] r32;
        logic [5:0]  sh;
        sh = b[5:0];
        if (ref_is_word(o, w)) begin
            case (o)
                ALU_ADD: r32 = a[31:0] + b[31:0];
                ALU_SUB: r32 = a[31:0] - b[31:0];
                ALU_SL:  r32 = a[31:0] << b[4:0];
                ALU_SRL: r32 = a[31:0] >> b[4:0];
                default: r32 = $signed(a[31:0]) >>> b[4:0];
            endcase
            return {{32{r32[31]}}, r32};
        end
        case (o)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLT:  return {63'd0, $signed(a) < $signed(b)};
            ALU_SLTU: return {63'd0, a < b};
            ALU_XOR:  return a ^ b;
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            ALU_SL:   return a << sh;
            ALU_SRL:  return a >> sh;
            ALU_SRA:  return $signed(a) >>> sh;
            default:  return 64'd0;
        endcase
    endfunction

    // One transaction on instance idx: accept, latency, result, stall, handshake.
    task automatic run_op(input int idx, input alu_op_t o, input bit w, input logic [63:0] a,
                          input logic [63:0] b, input int stall, output logic [63:0] got);
        logic [63:0] exp;
        int          n;
        int          edges;
        exp = ref_alu(o, w, a, b);
        n   = ref_digits(8 << idx, o, w);
        op = o; is32 = w; rs1 = a; opb = b;
        in_valid_v[idx] = 1'b1;
        check("in_ready_idle", {63'd0, in_ready_w[idx]}, 64'd1);
        @(posedge clock); #1;
        in_valid_v[idx] = 1'b0;
        op   = alu_op_t'(4'($urandom_range(0, 15)));
        is32 = 1'($urandom);
        rs1  = {$urandom, $urandom};
        opb  = {$urandom, $urandom};
        check("busy_after_accept", {63'd0, busy_w[idx]}, 64'd1);
        edges = 0;
        while (out_valid_w[idx] !== 1'b1 && edges < 300) begin
            @(posedge clock); #1;
            edges++;
        end
        check("latency", 64'(edges), 64'(n));
        check("result", result_w[idx], exp);
        for (int s = 0; s < stall; s++) begin
            @(posedge clock); #1;
            check("stall_valid", {63'd0, out_valid_w[idx]}, 64'd1);
            check("stall_result", result_w[idx], exp);
            check("stall_in_ready", {63'd0, in_ready_w[idx]}, 64'd0);
        end
        got = result_w[idx];
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        check("valid_after_handshake", {63'd0, out_valid_w[idx]}, 64'd0);
    endtask

    initial begin
        logic [63:0] got;
        logic [63:0] a;
        logic [63:0] b;
        bit          seen_valid;
        alu_op_t     o;

        reset = 1'b0; flush = 1'b0; in_valid_v = '0; out_ready = 1'b0;
        op = ALU_ADD; is32 = 1'b0; rs1 = '0; opb = '0;
        repeat (2) @(posedge clock);
        #3 reset = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < 4; i++) begin
            check("rst_in_ready", {63'd0, in_ready_w[i]}, 64'd1);
            check("rst_out_valid", {63'd0, out_valid_w[i]}, 64'd0);
            check("rst_busy", {63'd0, busy_w[i]}, 64'd0);
            check("rst_result", result_w[i], 64'd0);
        end

        run_op(0, ALU_ADD, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'd1, 0, got);
        check("add_carry", got, 64'h0000_0001_0000_0000);
        run_op(0, ALU_ADD, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd1, 0, got);
        check("addw", got, 64'hFFFF_FFFF_8000_0000);
        run_op(0, ALU_SUB, 1'b0, 64'd0, 64'd1, 0, got);
        check("sub", got, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(0, ALU_SLT, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, got);
        check("slt_neg", got, 64'd1);
        run_op(0, ALU_SLTU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, got);
        check("sltu_big", got, 64'd0);
        run_op(0, ALU_SLTU, 1'b0, 64'h0100_0000_0000_0000, 64'h00FF_FFFF_FFFF_FFFF, 0, got);
        check("sltu_top_digit", got, 64'd0);
        run_op(0, ALU_SLT, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 0, got);
        check("slt_equal", got, 64'd0);
        run_op(0, ALU_SRA, 1'b0, 64'h8000_0000_0000_0000, 64'd63, 5, got);
        check("sra_63", got, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(0, ALU_SRA, 1'b1, 64'h0000_0000_8000_0000, 64'd4, 0, got);
        check("sraw", got, 64'hFFFF_FFFF_F800_0000);
        run_op(0, ALU_SRL, 1'b1, 64'h0000_0000_8000_0000, 64'd4, 0, got);
        check("srlw", got, 64'h0000_0000_0800_0000);
        run_op(0, alu_op_t'(4'd13), 1'b0, 64'hFFFF_0000_FFFF_0000, 64'd7, 0, got);
        check("unknown_op", got, 64'd0);
        run_op(0, ALU_SL, 1'b0, 64'h0123_4567_89AB_CDEF, 64'd0, 0, got);
        check("sl_zero", got, 64'h0123_4567_89AB_CDEF);

        // Flush while digit 3 is being processed.
        op = ALU_ADD; is32 = 1'b0; rs1 = 64'd5; opb = 64'd6; in_valid_v[0] = 1'b1;
        @(posedge clock); #1;
        in_valid_v[0] = 1'b0;
        repeat (3) @(posedge clock);
        #1 flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        check("flush_busy", {63'd0, busy_w[0]}, 64'd0);
        check("flush_result", result_w[0], 64'h0123_4567_89AB_CDEF);
        seen_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clock); #1;
            if (out_valid_w[0]) seen_valid = 1'b1;
        end
        check("flush_no_valid", {63'd0, seen_valid}, 64'd0);

        // Flush beats a simultaneous request.
        flush = 1'b1; in_valid_v[0] = 1'b1;
        #1 check("flush_in_ready", {63'd0, in_ready_w[0]}, 64'd0);
        @(posedge clock); #1;
        flush = 1'b0; in_valid_v[0] = 1'b0;
        check("flush_no_accept", {63'd0, busy_w[0]}, 64'd0);

        // Asynchronous reset in the middle of RUN.
        op = ALU_XOR; rs1 = 64'hAAAA; opb = 64'h5555; in_valid_v[0] = 1'b1;
        @(posedge clock); #1;
        in_valid_v[0] = 1'b0;
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("midrst_in_ready", {63'd0, in_ready_w[0]}, 64'd1);
        check("midrst_busy", {63'd0, busy_w[0]}, 64'd0);
        check("midrst_out_valid", {63'd0, out_valid_w[0]}, 64'd0);
        check("midrst_result", result_w[0], 64'd0);
        #2 reset = 1'b1;
        @(posedge clock); #1;

        // Random sweep over every digit width, back-to-back with random stalls.
        for (int idx = 0; idx < 4; idx++) begin
            for (int t = 0; t < 40; t++) begin
                o = ($urandom_range(0, 15) == 0) ? alu_op_t'(4'($urandom_range(10, 15)))
                                                 : alu_op_t'(4'($urandom_range(0, 9)));
                a = {$urandom, $urandom};
                case ($urandom_range(0, 3))
                    0:       b = a;
                    1:       b = 64'($urandom_range(0, 70));
                    default: b = {$urandom, $urandom};
                endcase
                if ($urandom_range(0, 3) == 0) a[63] = 1'b1;
                run_op(idx, o, 1'($urandom), a, b, $urandom_range(0, 3), got);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
